// File: rtl/adler32_pkg.sv
// rtl/adler32_pkg.sv - Adler-32 constants, FSM state type and modulo-65521 folding helper
package adler32_pkg;

    localparam logic [15:0] ADLER_MOD  = 16'd65521;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FLUSH,
        DONE
    } state_e;

    // 2^16 = 15 (mod 65521). Three folds bring any 40-bit value to <= 65550,
    // so a single conditional subtract finishes the reduction.
    function automatic logic [15:0] mod65521_fold(input logic [39:0] x);
        logic [39:0] v;
        v = x;
        for (int i = 0; i < 3; i++) begin
            v = {24'd0, v[15:0]} + 40'(v[39:16]) * 40'd15;
        end
        if (v >= 40'(ADLER_MOD)) begin
            v = v - 40'(ADLER_MOD);
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/adler32_if.sv
// rtl/adler32_if.sv - beat input, seed/start control and checksum result bundle
interface adler32_if #(
    parameter int BYTE_NUM = 4
);
    localparam int DATA_WD = 8 * BYTE_NUM;
    localparam int NUM_WD  = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

    logic               start_i;
    logic               seed_en_i;
    logic [31:0]        seed_i;
    logic               val_i;
    logic [DATA_WD-1:0] dat_i;
    logic [NUM_WD-1:0]  num_i;
    logic               lst_i;
    logic               done_o;
    logic               val_o;
    logic [31:0]        dat_o;

    modport master (
        output start_i, seed_en_i, seed_i, val_i, dat_i, num_i, lst_i,
        input  done_o, val_o, dat_o
    );

    modport slave (
        input  start_i, seed_en_i, seed_i, val_i, dat_i, num_i, lst_i,
        output done_o, val_o, dat_o
    );

endinterface

// File: rtl/adler32_beat_sum.sv
// rtl/adler32_beat_sum.sv - masked byte sum and position-weighted sum of one beat
module adler32_beat_sum #(
    parameter int BYTE_NUM = 4,
    parameter int NUM_WD   = 2,
    parameter int N_WD     = 3,
    parameter int SUM_WD   = 10,
    parameter int WSUM_WD  = 14
) (
    input  logic [8*BYTE_NUM-1:0] dat_i,
    input  logic [NUM_WD-1:0]     num_i,
    input  logic                  lst_i,
    output logic [N_WD-1:0]       n_o,
    output logic [SUM_WD-1:0]     sum_o,
    output logic [WSUM_WD-1:0]    wsum_o
);

    int n_int;
    int sum_int;
    int wsum_int;

    // Byte k (k=0 in the top lane) contributes (n-k) times to B, since B adds the running A after every byte.
    always_comb begin
        n_int = lst_i ? int'(num_i) + 1 : BYTE_NUM;
        if (n_int > BYTE_NUM) begin
            n_int = BYTE_NUM;
        end
        sum_int  = 0;
        wsum_int = 0;
        for (int k = 0; k < BYTE_NUM; k++) begin
            if (k < n_int) begin
                sum_int  = sum_int + int'(dat_i[8*(BYTE_NUM-k)-1 -: 8]);
                wsum_int = wsum_int + (n_int - k) * int'(dat_i[8*(BYTE_NUM-k)-1 -: 8]);
            end
        end
        n_o    = N_WD'(n_int);
        sum_o  = SUM_WD'(sum_int);
        wsum_o = WSUM_WD'(wsum_int);
    end

endmodule

// File: rtl/adler32_par.sv
// rtl/adler32_par.sv - multi-byte-per-beat Adler-32 engine with seed load, abort and 2-stage pipe
module adler32_par
    import adler32_pkg::*;
#(
    parameter int          BYTE_NUM = 4,
    parameter logic [31:0] SEED_DEF = ADLER_INIT
) (
    input logic       clk,
    input logic       rst,
    adler32_if.slave  bus
);

    localparam int NUM_WD  = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam int N_WD    = NUM_WD + 1;
    localparam int SUM_WD  = 8 + $clog2(BYTE_NUM);
    localparam int WSUM_WD = 8 + 2 * $clog2(BYTE_NUM + 1);

    state_e               state_q, state_d;
    logic                 accept, emit;
    logic                 s1_vld_q, s2_vld_q;
    logic [N_WD-1:0]      s1_n_q, n_c;
    logic [SUM_WD-1:0]    s1_sum_q, sum_c;
    logic [WSUM_WD-1:0]   s1_wsum_q, wsum_c;
    logic [15:0]          a_q, b_q, a_d, b_d;
    logic [39:0]          a_pre, b_pre;
    logic [31:0]          seed_c, res_q;
    logic                 done_q, val_q;

    adler32_beat_sum #(
        .BYTE_NUM (BYTE_NUM),
        .NUM_WD   (NUM_WD),
        .N_WD     (N_WD),
        .SUM_WD   (SUM_WD),
        .WSUM_WD  (WSUM_WD)
    ) u_beat_sum (
        .dat_i  (bus.dat_i),
        .num_i  (bus.num_i),
        .lst_i  (bus.lst_i),
        .n_o    (n_c),
        .sum_o  (sum_c),
        .wsum_o (wsum_c)
    );

    assign seed_c = bus.seed_en_i ? bus.seed_i : SEED_DEF;

    // B uses the A from before this beat; the S1 weights already account for in-beat growth.
    assign a_pre = 40'(a_q) + 40'(s1_sum_q);
    assign b_pre = 40'(b_q) + 40'(s1_n_q) * 40'(a_q) + 40'(s1_wsum_q);
    assign a_d   = mod65521_fold(a_pre);
    assign b_d   = mod65521_fold(b_pre);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        emit    = 1'b0;
        if (bus.start_i) begin
            accept  = bus.val_i;
            state_d = (bus.val_i && bus.lst_i) ? FLUSH : BUSY;
        end else begin
            case (state_q)
                BUSY: begin
                    accept = bus.val_i;
                    if (bus.val_i && bus.lst_i) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    if (!s1_vld_q && !s2_vld_q) begin
                        state_d = DONE;
                        emit    = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_n_q    <= '0;
            s1_sum_q  <= '0;
            s1_wsum_q <= '0;
            a_q       <= 16'd1;
            b_q       <= 16'd0;
            done_q    <= 1'b0;
            val_q     <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= accept;
            val_q    <= emit;
            if (accept) begin
                s1_n_q    <= n_c;
                s1_sum_q  <= sum_c;
                s1_wsum_q <= wsum_c;
            end
            // start drops whatever sits in S1 and reseeds; a beat accepted with start lands on the seed.
            if (bus.start_i) begin
                a_q      <= seed_c[15:0];
                b_q      <= seed_c[31:16];
                s2_vld_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
                if (emit) begin
                    done_q <= 1'b1;
                    res_q  <= {b_q, a_q};
                end
            end
        end
    end

    assign bus.done_o = done_q;
    assign bus.val_o  = val_q;
    assign bus.dat_o  = res_q;

endmodule

// File: tb/tb_adler32_par.sv
// tb/tb_adler32_par.sv - self-checking bench for adler32_par at BYTE_NUM=4 and BYTE_NUM=1
module tb_adler32_par;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adler32_if #(.BYTE_NUM(4)) if4 ();
    adler32_if #(.BYTE_NUM(1)) if1 ();

    adler32_par #(.BYTE_NUM(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    adler32_par #(.BYTE_NUM(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nval4  = 0;
    int nval1  = 0;
    logic [31:0] exp_d4[$];
    logic [31:0] exp_d1[$];
    int          exp_t4[$];
    int          exp_t1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Byte-at-a-time reference Adler-32 starting from a {B,A} seed.
    function automatic logic [31:0] adler(input logic [31:0] seed, input bq_t m);
        int unsigned a, b;
        a = 32'(seed[15:0]);
        b = 32'(seed[31:16]);
        foreach (m[i]) begin
            a = (a + 32'(m[i])) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (if4.val_o) begin
                nval4++;
                if (exp_d4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_val_w4 actual=%h expected=no pulse", if4.dat_o);
                end else begin
                    chk("model_dat_w4", if4.dat_o, exp_d4.pop_front());
                    chk("latency_w4", cyc, exp_t4.pop_front());
                    chk("done_with_val_w4", 32'(if4.done_o), 32'd1);
                end
            end
            if (if1.val_o) begin
                nval1++;
                if (exp_d1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_val_w1 actual=%h expected=no pulse", if1.dat_o);
                end else begin
                    chk("model_dat_w1", if1.dat_o, exp_d1.pop_front());
                    chk("latency_w1", cyc, exp_t1.pop_front());
                    chk("done_with_val_w1", 32'(if1.done_o), 32'd1);
                end
            end
        end
    end

    task automatic drv(input int w, input bit st, input bit se, input logic [31:0] sd,
                       input bit v, input logic [31:0] d, input int num, input bit l);
        if (w == 4) begin
            if4.start_i = st; if4.seed_en_i = se; if4.seed_i = sd; if4.val_i = v;
            if4.dat_i = d; if4.num_i = 2'(num); if4.lst_i = l;
        end else begin
            if1.start_i = st; if1.seed_en_i = se; if1.seed_i = sd; if1.val_i = v;
            if1.dat_i = d[31:24]; if1.num_i = 1'(num); if1.lst_i = l;
        end
    endtask

    // Called at a negedge; unused lanes of a partial beat carry 0xA5 to prove masking.
    task automatic send(input int w, input bq_t m, input bit do_start, input bit se,
                        input logic [31:0] sd, input bit sep_start, input bit last);
        int n, nb;
        n  = m.size();
        nb = (n + w - 1) / w;
        if (do_start && sep_start) begin
            drv(w, 1'b1, se, sd, 1'b0, 32'd0, 0, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < nb; i++) begin
            logic [31:0] beat;
            int cnt;
            beat = 32'hA5A5_A5A5;
            cnt  = (n - i * w < w) ? n - i * w : w;
            for (int k = 0; k < cnt; k++) beat[31 - 8*k -: 8] = m[i*w + k];
            drv(w, do_start && !sep_start && i == 0, se, sd, 1'b1, beat, cnt - 1, last && i == nb - 1);
            if (last && i == nb - 1) begin
                if (w == 4) begin
                    exp_d4.push_back(adler(se ? sd : 32'h1, m)); exp_t4.push_back(cyc + 4);
                end else begin
                    exp_d1.push_back(adler(se ? sd : 32'h1, m)); exp_t1.push_back(cyc + 4);
                end
            end
            @(negedge clk);
        end
        drv(w, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b0);
    endtask

    task automatic wait_val(input int w);
        for (int i = 0; i < 12; i++) begin
            if ((w == 4) ? if4.val_o : if1.val_o) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL timeout_val_w%0d actual=no pulse expected=val_o within 12 cycles", w);
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && (exp_d4.size() + exp_d1.size()) != 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("drain", 32'(exp_d4.size() + exp_d1.size()), 32'd0);
    endtask

    initial begin
        bq_t m;
        int  ws[2] = '{4, 1};
        int  pre;

        rst = 1'b1;
        drv(4, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_done_w4", 32'(if4.done_o), 0);
        chk("reset_val_w4",  32'(if4.val_o), 0);
        chk("reset_dat_w4",  if4.dat_o, 0);
        chk("reset_done_w1", 32'(if1.done_o), 0);
        chk("reset_val_w1",  32'(if1.val_o), 0);
        chk("reset_dat_w1",  if1.dat_o, 0);
        rst = 1'b0;

        chk("pin_wikipedia", adler(32'h1, str2q("Wikipedia")), 32'h11E6_0398);
        chk("pin_abc",       adler(32'h1, str2q("abc")),       32'h024D_0127);
        chk("pin_wiki",      adler(32'h1, str2q("Wiki")),      32'h03DA_0195);
        chk("pin_resume",    adler(32'h03DA_0195, str2q("pedia")), 32'h11E6_0398);

        // beat while IDLE must be ignored
        drv(4, 0, 0, 0, 1, 32'h6162_6364, 3, 1);
        drv(1, 0, 0, 0, 1, 32'h6100_0000, 0, 1);
        @(negedge clk);
        drv(4, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk("idle_done_w4", 32'(if4.done_o), 0);
        chk("idle_done_w1", 32'(if1.done_o), 0);

        foreach (ws[j]) begin
            int w;
            w = ws[j];
            send(w, str2q("Wikipedia"), 1, 0, 0, 1, 1);
            wait_val(w);
            chk($sformatf("wikipedia_w%0d", w), (w == 4) ? if4.dat_o : if1.dat_o, 32'h11E6_0398);
            repeat (2) @(negedge clk);
            chk($sformatf("hold_w%0d", w), (w == 4) ? if4.dat_o : if1.dat_o, 32'h11E6_0398);
            chk($sformatf("done_level_w%0d", w), 32'((w == 4) ? if4.done_o : if1.done_o), 1);

            send(w, str2q("abc"), 1, 0, 0, 0, 1);
            wait_val(w);
            chk($sformatf("abc_w%0d", w), (w == 4) ? if4.dat_o : if1.dat_o, 32'h024D_0127);

            send(w, str2q("Wiki"), 1, 0, 0, 0, 1);
            wait_val(w);
            chk($sformatf("wiki_w%0d", w), (w == 4) ? if4.dat_o : if1.dat_o, 32'h03DA_0195);
            send(w, str2q("pedia"), 1, 1, 32'h03DA_0195, 1, 1);
            wait_val(w);
            chk($sformatf("resume_w%0d", w), (w == 4) ? if4.dat_o : if1.dat_o, 32'h11E6_0398);
            settle();

            pre = (w == 4) ? nval4 : nval1;
            send(w, str2q("Wikiped"), 1, 0, 0, 0, 0);
            send(w, str2q("abc"), 1, 0, 0, 0, 1);
            wait_val(w);
            chk($sformatf("abort_abc_w%0d", w), (w == 4) ? if4.dat_o : if1.dat_o, 32'h024D_0127);
            settle();
            chk($sformatf("abort_pulses_w%0d", w), 32'(((w == 4) ? nval4 : nval1) - pre), 1);

            pre = (w == 4) ? nval4 : nval1;
            send(w, str2q("abc"), 1, 0, 0, 0, 1);
            wait_val(w);
            send(w, str2q("Wikipedia"), 1, 0, 0, 0, 1);
            settle();
            chk($sformatf("b2b_pulses_w%0d", w), 32'(((w == 4) ? nval4 : nval1) - pre), 2);

            for (int len = 1; len <= 9; len++) begin
                m = {};
                for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
                send(w, m, 1, len[0], 32'h1234_0042 + 32'(len), 0, 1);
                wait_val(w);
            end
            settle();
        end

        send(4, str2q("Wikiped"), 1, 0, 0, 0, 0);
        send(1, str2q("Wik"), 1, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_done_w4", 32'(if4.done_o), 0);
        chk("rst_mid_val_w4",  32'(if4.val_o), 0);
        chk("rst_mid_dat_w4",  if4.dat_o, 0);
        chk("rst_mid_done_w1", 32'(if1.done_o), 0);
        chk("rst_mid_dat_w1",  if1.dat_o, 0);
        settle();

        m = {};
        repeat (99996 + $urandom_range(1, 4)) m.push_back(8'hFF);
        send(4, m, 1, 0, 0, 0, 1);
        wait_val(4);
        m = {};
        repeat (2003) m.push_back(8'hFF);
        send(1, m, 1, 0, 0, 0, 1);
        wait_val(1);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
